// File: rtl/handshake_receiver_if.sv
// Signal bundle for the handshake receiver: raw opponent line and game state in,
// qualified pulses and link status out.
interface handshake_receiver_if;
  logic handshake_in;
  logic game_active;
  logic ACK_received;
  logic game_end;
  logic frame_error;
  logic link_idle;

  modport master (
    output handshake_in,
    output game_active,
    input  ACK_received,
    input  game_end,
    input  frame_error,
    input  link_idle
  );

  modport slave (
    input  handshake_in,
    input  game_active,
    output ACK_received,
    output game_end,
    output frame_error,
    output link_idle
  );
endinterface

// File: rtl/handshake_receiver.sv
// Receive-side handshake decoder: synchronizes the opponent line, deframes start/data/stop
// frames and turns repeated ACK / GAME_END codes into single-cycle pulses.
module handshake_receiver #(
  parameter int unsigned       CODE_W       = 4,
  parameter logic [CODE_W-1:0] ACK_CODE     = 4'b0101,
  parameter logic [CODE_W-1:0] END_CODE     = 4'b1010,
  parameter int unsigned       REPEAT       = 2,
  parameter int unsigned       IDLE_TIMEOUT = 1024
) (
  input logic                 clk,
  input logic                 rst_l,
  handshake_receiver_if.slave bus
);

  localparam int unsigned BitCntW = (CODE_W > 1) ? $clog2(CODE_W) : 1;
  localparam int unsigned RepW    = $clog2(REPEAT + 1);
  localparam int unsigned IdleW   = $clog2(IDLE_TIMEOUT + 1);

  localparam logic [BitCntW-1:0] LastBit = BitCntW'(CODE_W - 1);
  localparam logic [RepW-1:0]    RepMax  = RepW'(REPEAT);
  localparam logic [RepW-1:0]    RepOne  = RepW'(1);
  localparam logic [IdleW-1:0]   IdleMax = IdleW'(IDLE_TIMEOUT);

  typedef enum logic [1:0] {
    StWaitStart,
    StData,
    StStop
  } state_e;

  logic                sync1_q;
  logic                hs_s_q;
  state_e              state_q, state_d;
  logic [BitCntW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [CODE_W-1:0]   shift_q, shift_d;
  logic [CODE_W-1:0]   last_code_q, last_code_d;
  logic [RepW-1:0]     repeat_cnt_q, repeat_cnt_d;
  logic [IdleW-1:0]    idle_cnt_q, idle_cnt_d;
  logic                ack_q, ack_d;
  logic                end_q, end_d;
  logic                err_q, err_d;
  logic                idle_q, idle_d;
  logic                frame_ok;
  logic                fire;
  logic                known_code;
  logic [RepW-1:0]     rep_sat_inc;

  // Two-flop synchronizer; only hs_s_q is used downstream.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      sync1_q <= 1'b0;
      hs_s_q  <= 1'b0;
    end else begin
      sync1_q <= bus.handshake_in;
      hs_s_q  <= sync1_q;
    end
  end

  assign known_code  = (shift_q == ACK_CODE) || (shift_q == END_CODE);
  assign rep_sat_inc = (repeat_cnt_q == RepMax) ? repeat_cnt_q : repeat_cnt_q + RepOne;

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    last_code_d  = last_code_q;
    repeat_cnt_d = repeat_cnt_q;
    ack_d        = 1'b0;
    end_d        = 1'b0;
    err_d        = 1'b0;
    frame_ok     = 1'b0;
    fire         = 1'b0;

    unique case (state_q)
      StWaitStart: begin
        if (hs_s_q) begin
          state_d   = StData;
          bit_cnt_d = '0;
        end
      end
      StData: begin
        // LSB arrives first, so shifting in at the MSB leaves it in bit 0.
        shift_d   = CODE_W'({hs_s_q, shift_q} >> 1);
        bit_cnt_d = bit_cnt_q + BitCntW'(1);
        if (bit_cnt_q == LastBit) begin
          state_d = StStop;
        end
      end
      StStop: begin
        state_d = StWaitStart;
        if (hs_s_q) begin
          err_d = 1'b1;
        end else begin
          frame_ok = 1'b1;
          if (known_code) begin
            if (shift_q == last_code_q) begin
              repeat_cnt_d = rep_sat_inc;
              fire         = (repeat_cnt_q != RepMax) && (rep_sat_inc == RepMax);
            end else begin
              last_code_d  = shift_q;
              repeat_cnt_d = RepOne;
              fire         = (RepOne == RepMax);
            end
            ack_d = fire && (shift_q == ACK_CODE);
            end_d = fire && (shift_q == END_CODE);
          end else begin
            err_d        = 1'b1;
            repeat_cnt_d = '0;
          end
        end
      end
      default: state_d = StWaitStart;
    endcase

    // Outside a game the qualifier is held cleared; deframing and errors keep running.
    if (!bus.game_active) begin
      repeat_cnt_d = '0;
      last_code_d  = '0;
      ack_d        = 1'b0;
      end_d        = 1'b0;
    end
  end

  always_comb begin
    if (frame_ok) begin
      idle_cnt_d = '0;
    end else if (idle_cnt_q == IdleMax) begin
      idle_cnt_d = idle_cnt_q;
    end else begin
      idle_cnt_d = idle_cnt_q + IdleW'(1);
    end
    idle_d = (idle_cnt_d == IdleMax);
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q      <= StWaitStart;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      last_code_q  <= '0;
      repeat_cnt_q <= '0;
      idle_cnt_q   <= IdleMax;
      ack_q        <= 1'b0;
      end_q        <= 1'b0;
      err_q        <= 1'b0;
      idle_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      last_code_q  <= last_code_d;
      repeat_cnt_q <= repeat_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
      ack_q        <= ack_d;
      end_q        <= end_d;
      err_q        <= err_d;
      idle_q       <= idle_d;
    end
  end

  assign bus.ACK_received = ack_q;
  assign bus.game_end     = end_q;
  assign bus.frame_error  = err_q;
  assign bus.link_idle    = idle_q;

  pulses_exclusive_a: assert property (@(posedge clk) disable iff (!rst_l)
    $onehot0({ack_q, end_q, err_q}));

endmodule

// File: tb/tb_handshake_receiver.sv
// Scoreboard bench: frame-level reference model predicts pulses and idle clears with
// their cycle stamps; a negedge monitor pops and compares.
module tb_handshake_receiver;
  localparam int unsigned CODE_W       = 4;
  localparam logic [3:0]  ACK          = 4'b0101;
  localparam logic [3:0]  ENDC         = 4'b1010;
  localparam int unsigned REPEAT       = 2;
  localparam int unsigned IDLE_TIMEOUT = 1024;

  typedef enum int {EvAck, EvEnd, EvErr} ev_e;
  typedef struct {
    ev_e         kind;
    int unsigned stamp;
  } ev_t;

  logic        clk   = 1'b0;
  logic        rst_l = 1'b0;
  int unsigned cyc   = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  ev_t         exp_q[$];
  int unsigned clr_q[$];

  // Reference model state (frame level).
  logic [3:0]  m_last     = '0;
  int unsigned m_cnt      = 0;
  bit          m_ga       = 1'b0;
  bit          m_have_clr = 1'b0;
  int unsigned m_clr_at   = 0;
  bit          prev_exp_idle = 1'b1;
  bit          prev_dut_idle = 1'b1;

  handshake_receiver_if hs ();

  handshake_receiver #(
    .CODE_W      (CODE_W),
    .ACK_CODE    (ACK),
    .END_CODE    (ENDC),
    .REPEAT      (REPEAT),
    .IDLE_TIMEOUT(IDLE_TIMEOUT)
  ) dut (
    .clk  (clk),
    .rst_l(rst_l),
    .bus  (hs)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic void push_ev(input ev_e k, input int unsigned st);
    ev_t e;
    e.kind  = k;
    e.stamp = st;
    exp_q.push_back(e);
  endfunction

  // Outcome of one complete frame; stamp is the cycle its response becomes visible.
  function automatic void model_frame(input logic [3:0] code, input logic stop,
                                      input int unsigned stamp);
    if (stop) begin
      push_ev(EvErr, stamp);
    end else begin
      clr_q.push_back(stamp);
      if (code == ACK || code == ENDC) begin
        if (m_ga) begin
          if (code == m_last) begin
            if (m_cnt < REPEAT) begin
              m_cnt++;
              if (m_cnt == REPEAT) push_ev((code == ACK) ? EvAck : EvEnd, stamp);
            end
          end else begin
            m_last = code;
            m_cnt  = 1;
            if (REPEAT == 1) push_ev((code == ACK) ? EvAck : EvEnd, stamp);
          end
        end
      end else begin
        push_ev(EvErr, stamp);
        m_cnt = 0;
      end
    end
  endfunction

  task automatic send_bit(input logic b);
    @(posedge clk);
    #1 hs.handshake_in = b;
  endtask

  task automatic send_frame(input logic [3:0] code, input logic stop);
    send_bit(1'b1);
    for (int i = 0; i < 4; i++) send_bit(code[i]);
    send_bit(stop);
    model_frame(code, stop, cyc + 3);
  endtask

  task automatic set_ga(input bit b);
    repeat (3) send_bit(1'b0);
    @(posedge clk);
    #1 hs.game_active = b;
    m_ga = b;
    if (!b) begin
      m_last = '0;
      m_cnt  = 0;
    end
  endtask

  // game_active low for exactly one sampling edge, then back high.
  task automatic drop_ga();
    repeat (3) send_bit(1'b0);
    @(posedge clk);
    #1 hs.game_active = 1'b0;
    @(posedge clk);
    #1 hs.game_active = 1'b1;
    m_ga   = 1'b1;
    m_last = '0;
    m_cnt  = 0;
  endtask

  always @(negedge clk) begin
    if (!rst_l) begin
      prev_exp_idle = 1'b1;
      prev_dut_idle = hs.link_idle;
    end else begin
      bit   exp_idle;
      int   n;
      ev_t  e;
      ev_e  got;
      while (clr_q.size() > 0 && clr_q[0] <= cyc) begin
        m_have_clr = 1'b1;
        m_clr_at   = clr_q.pop_front();
      end
      exp_idle = !m_have_clr || ((cyc - m_clr_at) >= IDLE_TIMEOUT);
      if (exp_idle != prev_exp_idle || hs.link_idle != prev_dut_idle)
        check("link_idle", hs.link_idle, exp_idle);
      prev_exp_idle = exp_idle;
      prev_dut_idle = hs.link_idle;

      while (exp_q.size() > 0 && exp_q[0].stamp < cyc) begin
        e = exp_q.pop_front();
        n_cmp++;
        n_bad++;
        $display("FAIL missing_pulse: got none expected %s at cycle %0d", e.kind.name(),
                 e.stamp);
      end

      n = int'(hs.ACK_received) + int'(hs.game_end) + int'(hs.frame_error);
      if (n > 0) begin
        check("pulse_exclusive", n, 1);
        got = hs.ACK_received ? EvAck : (hs.game_end ? EvEnd : EvErr);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_pulse: got %s expected none at cycle %0d", got.name(), cyc);
        end else begin
          e = exp_q.pop_front();
          check("pulse_kind", got, e.kind);
          check("pulse_cycle", cyc, e.stamp);
        end
      end
    end
  end

  initial begin
    hs.handshake_in = 1'b0;
    hs.game_active  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ack", hs.ACK_received, 0);
    check("rst_end", hs.game_end, 0);
    check("rst_err", hs.frame_error, 0);
    check("rst_idle", hs.link_idle, 1);
    rst_l = 1'b1;

    // Two back-to-back ACKs.
    set_ga(1'b1);
    send_frame(ACK, 1'b0);
    send_frame(ACK, 1'b0);

    // END, ACK, END, END: only the last END qualifies.
    repeat (3) send_bit(1'b0);
    send_frame(ENDC, 1'b0);
    send_frame(ACK, 1'b0);
    send_frame(ENDC, 1'b0);
    send_frame(ENDC, 1'b0);

    // Five ACKs, a one-cycle game_active drop, then two more.
    repeat (2) send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_frame(ACK, 1'b0);
    drop_ga();
    send_frame(ACK, 1'b0);
    send_frame(ACK, 1'b0);

    // Bad stop bit, then unknown code clearing the repeat count.
    repeat (3) send_bit(1'b0);
    send_frame(ACK, 1'b1);
    send_frame(ACK, 1'b0);
    send_frame(4'b1111, 1'b0);
    send_frame(ACK, 1'b0);
    send_frame(ACK, 1'b0);

    // Reset in the middle of a frame.
    repeat (5) send_bit(1'b0);
    send_bit(1'b1);
    send_bit(ACK[0]);
    send_bit(ACK[1]);
    send_bit(ACK[2]);
    @(posedge clk);
    #2 rst_l = 1'b0;
    exp_q.delete();
    clr_q.delete();
    m_have_clr = 1'b0;
    m_last     = '0;
    m_cnt      = 0;
    #1;
    check("midrst_ack", hs.ACK_received, 0);
    check("midrst_end", hs.game_end, 0);
    check("midrst_err", hs.frame_error, 0);
    check("midrst_idle", hs.link_idle, 1);
    hs.handshake_in = 1'b0;
    repeat (3) @(negedge clk);
    rst_l = 1'b1;
    repeat (2) send_bit(1'b0);
    send_frame(ACK, 1'b0);
    send_frame(ACK, 1'b0);

    // Game inactive: frames clear idle but never pulse; then wait out the timeout.
    set_ga(1'b0);
    for (int i = 0; i < 4; i++) send_frame(ACK, 1'b0);
    repeat (IDLE_TIMEOUT + 40) send_bit(1'b0);

    // Randomized traffic.
    set_ga(1'b1);
    for (int i = 0; i < 250; i++) begin
      int unsigned sel;
      logic [3:0]  code;
      logic        stop;
      sel  = $urandom_range(0, 9);
      code = (sel < 4) ? ACK : ((sel < 8) ? ENDC : 4'($urandom));
      stop = ($urandom_range(0, 7) == 0);
      send_frame(code, stop);
      repeat ($urandom_range(0, 2)) send_bit(1'b0);
      if ($urandom_range(0, 11) == 0) set_ga(!m_ga);
      else if ($urandom_range(0, 15) == 0) drop_ga();
    end

    repeat (8) send_bit(1'b0);
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/handshake_receiver.md
# handshake_receiver

Receive-side decoder for the inter-board handshake line in multiplayer games. Synchronizes the opponent's handshake GPIO, deframes serial control frames, and qualifies ACK and GAME_END codes by requiring consecutive repeats. It produces the single-cycle `ACK_received` and `game_end` pulses consumed by the sender control FSM, and flags framing errors and link silence.

## Interface
- `CODE_W`, 4: data bits per frame.
- `ACK_CODE`, 4'b0101: code sent by an opponent in ready/won state.
- `END_CODE`, 4'b1010: code sent by an opponent that has topped out.
- `REPEAT`, 2: consecutive identical valid frames required before a pulse (≥1).
- `IDLE_TIMEOUT`, 1024: cycles without a valid frame before `link_idle` asserts.

Ports:
- `clk`  in  1  GPIO clock, shared with the opponent's transmitter.
- `rst_l`  in  1  asynchronous active-low reset.
- `handshake_in`  in  1  raw handshake line from the opponent; asynchronous to the capture flops.
- `game_active`  in  1  enables pulse generation; high in ready, in-game, lost and won states.
- `ACK_received`  out  1  one-cycle pulse on a qualified ACK.
- `game_end`  out  1  one-cycle pulse on a qualified GAME_END (the opponent lost).
- `frame_error`  out  1  one-cycle pulse on a bad stop bit or an unknown code.
- `link_idle`  out  1  level; no valid frame for ≥`IDLE_TIMEOUT` cycles.

## Operation
- Line idles low. A frame is: start bit 1, then `CODE_W` data bits LSB first, then stop bit 0. Each bit lasts one `clk` cycle.
- `handshake_in` passes through a 2-flop synchronizer. Its output `hs_s` is the only line value the logic uses.
- FSM states:
  - WAIT_START: `hs_s`=1 → DATA, with bit_cnt cleared.
  - DATA: shift `hs_s` into the MSB of the shift register and increment bit_cnt. After `CODE_W` bits → STOP.
  - STOP: `hs_s`=0 → decode the frame, then WAIT_START. `hs_s`=1 → `frame_error`, then WAIT_START. That 1 is not reused as a start bit.
- Decode of a valid frame:
  - Code is ACK or END and equals last_code: repeat_cnt increments, saturating at `REPEAT`.
  - Code is ACK or END and differs from last_code: last_code takes the new code and repeat_cnt = 1.
  - The output pulse fires only when repeat_cnt transitions to `REPEAT`. With `REPEAT`=1, every frame whose code differs from last_code fires. Further identical frames never re-fire until repeat_cnt is cleared or the code changes.
  - Any other code: `frame_error` pulses and repeat_cnt is cleared.
- `game_active` low:
  - repeat_cnt and last_code are held cleared (last_code = 0, which is not a valid code).
  - No `ACK_received` or `game_end` pulses are produced.
  - Deframing continues so that bit alignment is kept.
  - `frame_error` and `link_idle` still operate.
- `link_idle` counter:
  - Any valid frame (ACK, END or unknown code with a good stop bit) zeroes it. Otherwise it increments every cycle and saturates at `IDLE_TIMEOUT`.
  - `link_idle` = (count == `IDLE_TIMEOUT`).
- `ACK_received`, `game_end` and `frame_error` are mutually exclusive in any cycle.

## Timing
- Reset values:
  - FSM = WAIT_START; synchronizer flops = 0; bit_cnt = 0; repeat_cnt = 0; last_code = 0.
  - idle count = `IDLE_TIMEOUT`, so `link_idle` = 1.
  - `ACK_received`, `game_end`, `frame_error` = 0.
- All outputs are registered.
- Latency: let edge k be the edge that captures the stop bit into synchronizer stage 1. The pulse is high from edge k+2 to edge k+3. `link_idle` deasserts at edge k+2.
- Frames may be sent back to back: a start bit may immediately follow a stop bit, which gives a 6-cycle period for `CODE_W`=4.
- Reset assertion mid-frame aborts immediately. After release, the partial frame's remaining bits are treated as a new frame only if a 1 appears while in WAIT_START.
- `game_active` falling mid-frame: the frame completes. If the stop bit is good it decodes with repeat_cnt and last_code cleared and produces no pulse.
- `game_active` rising: a pulse needs `REPEAT` complete frames, all starting at or after the rising edge seen by decode.

## Test plan
- Reset, then `game_active`=1, then two back-to-back ACK frames (line 1,1,0,1,0,0 ×2) → `ACK_received` high exactly one cycle, at edge k+2 of the second stop bit. `link_idle` goes 1→0.
- `game_active`=1, then END, ACK, END, END → single `game_end` pulse after the fourth frame only. No `ACK_received` pulse.
- Five consecutive ACK frames → exactly one `ACK_received` pulse (after frame 2). Then drop `game_active` for 1 cycle between frames, then two more ACK frames → a second pulse.
- ACK frame with stop bit 1 → `frame_error` pulse and no ACK count. Code 4'b1111 with good stop → `frame_error` pulse and repeat_cnt cleared.
- `game_active`=0 with four ACK frames → no pulses, no errors. `link_idle`=0 after the first frame, and `link_idle`=1 again exactly `IDLE_TIMEOUT` cycles after the last counter clear.
- Assert `rst_l` low during DATA bit 2 of an ACK frame → all outputs at reset values within the same cycle. A clean frame pair after release is decoded normally.
